// File: rtl/axis_frame_gen_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axis_frame_gen_pkg : shared types and colour constants for the frame generator
// Rev 1.0
// ---------------------------------------------------------------------------
package axis_frame_gen_pkg;

  typedef enum logic [1:0] {
    MODE_COORD = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_CHECK = 2'd3
  } mode_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [23:0] C_RGB_WHITE = 24'hFFFFFF;
  localparam logic [23:0] C_RGB_BLACK = 24'h000000;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] C_BAR_COLOURS = {
    C_RGB_BLACK, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00,  24'h00FFFF, 24'hFFFF00, C_RGB_WHITE
  };

endpackage
`default_nettype wire

// File: rtl/axis_pattern_pixel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axis_pattern_pixel : combinational test-pattern colour for one pixel
// Rev 1.0
// ---------------------------------------------------------------------------
module axis_pattern_pixel
  import axis_frame_gen_pkg::*;
#(
  parameter int PIXEL_WIDTH = 24,
  parameter int HW          = 12,
  parameter int VW          = 12,
  parameter int CHECK_SHIFT = 3
) (
  input  logic [1:0]             mode_i,
  input  logic [HW-1:0]          px_i,
  input  logic [VW-1:0]          y_i,
  input  logic [7*HW-1:0]        thresh_i,
  input  logic [PIXEL_WIDTH-1:0] solid_i,
  output logic [PIXEL_WIDTH-1:0] pixel_o
);

  logic [2:0]       w_bar_idx;
  logic [VW+HW-1:0] w_coord;

  // Thresholds are monotonic, so counting those passed gives the bar index.
  always_comb begin
    w_bar_idx = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (px_i >= thresh_i[i*HW +: HW]) w_bar_idx = w_bar_idx + 3'd1;
    end
  end

  assign w_coord = {y_i, px_i};

  always_comb begin
    case (mode_e'(mode_i))
      MODE_COORD: pixel_o = PIXEL_WIDTH'(w_coord);
      MODE_BARS:  pixel_o = PIXEL_WIDTH'(C_BAR_COLOURS[w_bar_idx]);
      MODE_SOLID: pixel_o = solid_i;
      default:    pixel_o = (px_i[CHECK_SHIFT] ^ y_i[CHECK_SHIFT]) ?
                            PIXEL_WIDTH'(C_RGB_WHITE) : PIXEL_WIDTH'(C_RGB_BLACK);
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/axis_frame_generator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axis_frame_generator : AXI4-Stream video test-pattern frame source
// Rev 1.0
// ---------------------------------------------------------------------------
module axis_frame_generator
  import axis_frame_gen_pkg::*;
#(
  parameter int MAX_H_RES   = 2048,
  parameter int MAX_V_RES   = 2048,
  parameter int PPC         = 1,
  parameter int PIXEL_WIDTH = 24,
  parameter int DATA_WIDTH  = PPC*PIXEL_WIDTH,
  parameter int USER_WIDTH  = 1,
  parameter int CHECK_SHIFT = 3,
  parameter int HW          = $clog2(MAX_H_RES+1),
  parameter int VW          = $clog2(MAX_V_RES+1),
  parameter int KEEP_WIDTH  = (DATA_WIDTH+7)/8,
  parameter int ID_WIDTH    = 1,
  parameter int DEST_WIDTH  = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic [1:0]             mode_i,
  input  logic [HW-1:0]          h_res_i,
  input  logic [VW-1:0]          v_res_i,
  input  logic [PIXEL_WIDTH-1:0] solid_i,
  output logic                   busy_o,
  output logic                   cfg_err_o,
  output logic                   frame_done_o,
  output logic [15:0]            frame_cnt_o,
  output logic [HW-1:0]          x_o,
  output logic [VW-1:0]          y_o,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [USER_WIDTH-1:0]  m_axis_tuser,
  output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic [ID_WIDTH-1:0]    m_axis_tid,
  output logic [DEST_WIDTH-1:0]  m_axis_tdest
);

  state_e                  r_state;
  logic [HW-1:0]           r_h_res, r_x;
  logic [VW-1:0]           r_v_res, r_y;
  logic [1:0]              r_mode;
  logic [PIXEL_WIDTH-1:0]  r_solid;
  logic [7*HW-1:0]         r_thresh;
  logic                    r_valid, r_last, r_user, r_cfg_err, r_done;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [15:0]             r_frame_cnt;

  logic [HW-1:0]           w_bar_w, w_cfg_h, w_nx;
  logic [VW-1:0]           w_ny;
  logic [7*HW-1:0]         w_thresh_in, w_cfg_thresh;
  logic [1:0]              w_cfg_mode;
  logic [PIXEL_WIDTH-1:0]  w_cfg_solid;
  logic [DATA_WIDTH-1:0]   w_data;
  logic w_cfg_ok, w_fire, w_last_hs, w_start_pt, w_start, w_nlast;

  assign w_cfg_ok = (h_res_i >= HW'(PPC)) && (h_res_i <= HW'(MAX_H_RES)) &&
                    ((h_res_i & HW'(PPC-1)) == '0) &&
                    (v_res_i != '0) && (v_res_i <= VW'(MAX_V_RES));

  assign w_fire     = r_valid && m_axis_tready;
  assign w_last_hs  = w_fire && r_last && (r_y == r_v_res - VW'(1));
  assign w_start_pt = (r_state == IDLE) || w_last_hs;
  assign w_start    = w_start_pt && enable_i && w_cfg_ok;

  assign w_bar_w = h_res_i >> 3;
  always_comb begin
    w_thresh_in = '0;
    for (int i = 1; i < 8; i++) begin
      w_thresh_in[(i-1)*HW +: HW] = HW'(i) * w_bar_w;
    end
  end

  // Next-beat pixels see the incoming config at a start point, the latched one otherwise.
  assign w_cfg_h      = w_start ? h_res_i     : r_h_res;
  assign w_cfg_mode   = w_start ? mode_i      : r_mode;
  assign w_cfg_solid  = w_start ? solid_i     : r_solid;
  assign w_cfg_thresh = w_start ? w_thresh_in : r_thresh;

  always_comb begin
    w_nx = r_x;
    w_ny = r_y;
    if (w_start) begin
      w_nx = '0;
      w_ny = '0;
    end else if (r_last) begin
      w_nx = '0;
      w_ny = r_y + VW'(1);
    end else begin
      w_nx = r_x + HW'(PPC);
    end
  end

  assign w_nlast = (w_nx == w_cfg_h - HW'(PPC));

  for (genvar k = 0; k < PPC; k++) begin : g_lane
    axis_pattern_pixel #(
      .PIXEL_WIDTH (PIXEL_WIDTH),
      .HW          (HW),
      .VW          (VW),
      .CHECK_SHIFT (CHECK_SHIFT)
    ) u_pixel (
      .mode_i   (w_cfg_mode),
      .px_i     (w_nx + HW'(k)),
      .y_i      (w_ny),
      .thresh_i (w_cfg_thresh),
      .solid_i  (w_cfg_solid),
      .pixel_o  (w_data[k*PIXEL_WIDTH +: PIXEL_WIDTH])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_h_res     <= '0;
      r_v_res     <= '0;
      r_mode      <= '0;
      r_solid     <= '0;
      r_thresh    <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_user      <= 1'b0;
      r_data      <= '0;
      r_cfg_err   <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_done <= w_last_hs;
      if (w_last_hs) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_start_pt && enable_i) r_cfg_err <= !w_cfg_ok;

      if (w_start) begin
        r_state  <= RUN;
        r_h_res  <= h_res_i;
        r_v_res  <= v_res_i;
        r_mode   <= mode_i;
        r_solid  <= solid_i;
        r_thresh <= w_thresh_in;
        r_valid  <= 1'b1;
        r_x      <= w_nx;
        r_y      <= w_ny;
        r_data   <= w_data;
        r_last   <= w_nlast;
        r_user   <= 1'b1;
      end else if (w_last_hs || (r_state == IDLE)) begin
        r_state <= IDLE;
        r_valid <= 1'b0;
        r_x     <= '0;
        r_y     <= '0;
        r_data  <= '0;
        r_last  <= 1'b0;
        r_user  <= 1'b0;
      end else if (w_fire) begin
        r_x    <= w_nx;
        r_y    <= w_ny;
        r_data <= w_data;
        r_last <= w_nlast;
        r_user <= 1'b0;
      end
    end
  end

  assign busy_o        = (r_state == RUN);
  assign cfg_err_o     = r_cfg_err;
  assign frame_done_o  = r_done;
  assign frame_cnt_o   = r_frame_cnt;
  assign x_o           = r_x;
  assign y_o           = r_y;
  assign m_axis_tdata  = r_data;
  assign m_axis_tvalid = r_valid;
  assign m_axis_tlast  = r_last;
  assign m_axis_tuser  = USER_WIDTH'(r_user);
  assign m_axis_tkeep  = '1;
  assign m_axis_tid    = '0;
  assign m_axis_tdest  = '0;

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_generator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axis_frame_generator : scoreboard bench for three PPC variants of the generator
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_axis_frame_generator;

  typedef struct packed {
    logic [95:0] data;
    logic        last;
    logic        user;
    logic [11:0] x;
    logic [11:0] y;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT a: PPC=1, DUT b: PPC=2, DUT c: PPC=4
  logic        a_en, b_en, c_en;
  logic [1:0]  a_mode, b_mode, c_mode;
  logic [11:0] a_h, b_h, c_h, a_x, b_x, c_x;
  logic [11:0] a_v, b_v, c_v, a_y, b_y, c_y;
  logic [23:0] a_solid, b_solid, c_solid;
  logic        a_busy, b_busy, c_busy, a_err, b_err, c_err, a_done, b_done, c_done;
  logic [15:0] a_cnt, b_cnt, c_cnt;
  logic [23:0] a_tdata;
  logic [47:0] b_tdata;
  logic [95:0] c_tdata;
  logic        a_tvalid, b_tvalid, c_tvalid, a_tready, b_tready, c_tready;
  logic        a_tlast, b_tlast, c_tlast;
  logic [0:0]  a_tuser, b_tuser, c_tuser, a_tid, b_tid, c_tid, a_tdest, b_tdest, c_tdest;
  logic [2:0]  a_tkeep;
  logic [5:0]  b_tkeep;
  logic [11:0] c_tkeep;

  axis_frame_generator #(.PPC(1)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(a_en), .mode_i(a_mode), .h_res_i(a_h),
    .v_res_i(a_v), .solid_i(a_solid), .busy_o(a_busy), .cfg_err_o(a_err),
    .frame_done_o(a_done), .frame_cnt_o(a_cnt), .x_o(a_x), .y_o(a_y),
    .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(a_tready),
    .m_axis_tlast(a_tlast), .m_axis_tuser(a_tuser), .m_axis_tkeep(a_tkeep),
    .m_axis_tid(a_tid), .m_axis_tdest(a_tdest));

  axis_frame_generator #(.PPC(2)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(b_en), .mode_i(b_mode), .h_res_i(b_h),
    .v_res_i(b_v), .solid_i(b_solid), .busy_o(b_busy), .cfg_err_o(b_err),
    .frame_done_o(b_done), .frame_cnt_o(b_cnt), .x_o(b_x), .y_o(b_y),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready),
    .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser), .m_axis_tkeep(b_tkeep),
    .m_axis_tid(b_tid), .m_axis_tdest(b_tdest));

  axis_frame_generator #(.PPC(4)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(c_en), .mode_i(c_mode), .h_res_i(c_h),
    .v_res_i(c_v), .solid_i(c_solid), .busy_o(c_busy), .cfg_err_o(c_err),
    .frame_done_o(c_done), .frame_cnt_o(c_cnt), .x_o(c_x), .y_o(c_y),
    .m_axis_tdata(c_tdata), .m_axis_tvalid(c_tvalid), .m_axis_tready(c_tready),
    .m_axis_tlast(c_tlast), .m_axis_tuser(c_tuser), .m_axis_tkeep(c_tkeep),
    .m_axis_tid(c_tid), .m_axis_tdest(c_tdest));

  exp_t qa[$], qb[$], qc[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] pk(input logic [95:0] d, input logic l, input logic u,
                                      input logic [11:0] x, input logic [11:0] y);
    return {6'd0, d, l, u, x, y};
  endfunction

  task automatic push(input int q, input int x, input int y, input logic [95:0] d,
                      input bit last, input bit user);
    exp_t e;
    e.data = d; e.last = last; e.user = user; e.x = 12'(x); e.y = 12'(y);
    case (q)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  // Every valid cycle is checked against the queue head, so stalled beats must hold steady.
  task automatic mon(input int q, input logic vld, input logic rdy, input logic [127:0] act);
    exp_t e;
    int   n;
    if (!vld) return;
    n = (q == 0) ? qa.size() : (q == 1) ? qb.size() : qc.size();
    if (n == 0) begin
      chk($sformatf("dut%0d_unexpected_beat_queued", q), 128'(n), 128'd1);
      return;
    end
    e = (q == 0) ? qa[0] : (q == 1) ? qb[0] : qc[0];
    chk($sformatf("dut%0d_beat", q), act, pk(e.data, e.last, e.user, e.x, e.y));
    if (rdy) begin
      case (q)
        0:       void'(qa.pop_front());
        1:       void'(qb.pop_front());
        default: void'(qc.pop_front());
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, a_tvalid, a_tready, pk(96'(a_tdata), a_tlast, a_tuser[0], a_x, a_y));
      mon(1, b_tvalid, b_tready, pk(96'(b_tdata), b_tlast, b_tuser[0], b_x, b_y));
      mon(2, c_tvalid, c_tready, pk(c_tdata, c_tlast, c_tuser[0], c_x, c_y));
    end
  end

  function automatic logic done_of(input int w);
    return (w == 0) ? a_done : (w == 1) ? b_done : c_done;
  endfunction

  task automatic wait_done(input int w, input int budget, input bit rnd);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (w == 0) a_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (done_of(w)) begin
        seen = 1'b1;
        break;
      end
    end
    chk($sformatf("dut%0d_frame_done_seen", w), 128'(seen), 128'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int gap_valid;
    rst_n = 1'b0;
    a_en = 0; b_en = 0; c_en = 0;
    a_mode = 0; b_mode = 0; c_mode = 0;
    a_h = 0; b_h = 0; c_h = 0; a_v = 0; b_v = 0; c_v = 0;
    a_solid = 0; b_solid = 0; c_solid = 0;
    a_tready = 1; b_tready = 1; c_tready = 1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 128'({a_tvalid, b_tvalid, c_tvalid}), 128'd0);
    chk("rst_status", 128'({a_busy, a_err, a_done, a_cnt, a_x, a_y}), 128'd0);
    chk("rst_data", 128'({a_tdata, a_tlast, a_tuser}), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // PPC=1, 4x2 coordinates, always ready
    a_h = 4; a_v = 2; a_mode = 0;
    for (int yy = 0; yy < 2; yy++)
      for (int xx = 0; xx < 4; xx++)
        push(0, xx, yy, 96'({12'(yy), 12'(xx)}), xx == 3, (xx == 0) && (yy == 0));
    a_en = 1; @(posedge clk); #1; a_en = 0;
    wait_done(0, 100, 0);
    chk("t1_frame_cnt", 128'(a_cnt), 128'd1);
    @(negedge clk);
    chk("t1_done_is_pulse", 128'(a_done), 128'd0);
    chk("t1_idle_after", 128'({a_tvalid, a_busy}), 128'd0);

    // Same frame under random backpressure
    for (int yy = 0; yy < 2; yy++)
      for (int xx = 0; xx < 4; xx++)
        push(0, xx, yy, 96'({12'(yy), 12'(xx)}), xx == 3, (xx == 0) && (yy == 0));
    a_en = 1; @(posedge clk); #1; a_en = 0;
    wait_done(0, 300, 1);
    a_tready = 1;
    chk("t2_frame_cnt", 128'(a_cnt), 128'd2);
    chk("t2_queue_drained", 128'(qa.size()), 128'd0);

    // PPC=2, 16x1 colour bars: bar_w = 2, so beat b carries bar b in both lanes
    b_h = 16; b_v = 1; b_mode = 1;
    for (int b = 0; b < 8; b++)
      push(1, 2*b, 0, 96'({bars[b], bars[b]}), b == 7, b == 0);
    b_en = 1; @(posedge clk); #1; b_en = 0;
    wait_done(1, 100, 0);
    chk("t3_frame_cnt", 128'(b_cnt), 128'd1);

    // PPC=4: h=6 rejected, h=8 accepted; solid colour
    c_h = 6; c_v = 1; c_mode = 2; c_solid = 24'hABCDEF;
    c_en = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t4_cfg_err_set", 128'(c_err), 128'd1);
    chk("t4_no_start", 128'({c_tvalid, c_busy}), 128'd0);
    push(2, 0, 0, {4{24'hABCDEF}}, 1'b0, 1'b1);
    push(2, 4, 0, {4{24'hABCDEF}}, 1'b1, 1'b0);
    c_h = 8;
    @(posedge clk); #1; c_en = 0;
    @(negedge clk);
    chk("t4_cfg_err_clear", 128'(c_err), 128'd0);
    chk("t4_started", 128'(c_tvalid), 128'd1);
    wait_done(2, 50, 0);
    chk("t4_frame_cnt", 128'(c_cnt), 128'd1);

    // enable dropped mid-frame, 4x4 still completes
    do_reset();
    a_h = 4; a_v = 4; a_mode = 0;
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 4; xx++)
        push(0, xx, yy, 96'({12'(yy), 12'(xx)}), xx == 3, (xx == 0) && (yy == 0));
    a_en = 1; @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1; a_en = 0;
    wait_done(0, 100, 0);
    chk("t5_frame_cnt", 128'(a_cnt), 128'd1);
    @(negedge clk);
    chk("t5_tvalid_low_after", 128'(a_tvalid), 128'd0);

    // Checkerboard, h changed mid-frame: 16 beats old size, then 8 beats new size, no gap
    a_h = 16; a_v = 1; a_mode = 3;
    for (int xx = 0; xx < 16; xx++)
      push(0, xx, 0, (xx >= 8) ? 96'h0FFFFFF : 96'h0, xx == 15, xx == 0);
    for (int xx = 0; xx < 8; xx++)
      push(0, xx, 0, 96'h0, xx == 7, xx == 0);
    a_en = 1; @(posedge clk); #1;
    gap_valid = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (a_tvalid) gap_valid++;
      if (i == 0) a_h = 8;
      if (i == 20) a_en = 0;
    end
    chk("t6_zero_gap_valid_cycles", 128'(gap_valid), 128'd24);
    @(negedge clk);
    chk("t6_done_second_frame", 128'(a_done), 128'd1);
    chk("t6_tvalid_low_after", 128'(a_tvalid), 128'd0);
    chk("t6_frame_cnt", 128'(a_cnt), 128'd3);
    chk("t6_queue_drained", 128'(qa.size()), 128'd0);

    // Asynchronous reset in the middle of a frame
    a_h = 4; a_v = 2; a_mode = 0;
    for (int yy = 0; yy < 2; yy++)
      for (int xx = 0; xx < 4; xx++)
        push(0, xx, yy, 96'({12'(yy), 12'(xx)}), xx == 3, (xx == 0) && (yy == 0));
    a_en = 1; @(posedge clk); #1; a_en = 0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    qa.delete();
    chk("t7_rst_stream", 128'({a_tvalid, a_tlast, a_tuser, a_tdata}), 128'd0);
    chk("t7_rst_status", 128'({a_busy, a_err, a_done, a_cnt, a_x, a_y}), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t7_not_resumed", 128'({a_tvalid, a_busy}), 128'd0);

    chk("tieoff_a", 128'({a_tkeep, a_tid, a_tdest}), 128'({3'b111, 1'b0, 1'b0}));
    chk("tieoff_c", 128'({c_tkeep, c_tid, c_tdest}), 128'({12'hFFF, 1'b0, 1'b0}));
    chk("queues_drained", 128'(qa.size() + qb.size() + qc.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
